// File: rtl/pmem_responder_pkg.sv
// Shared types for the L2 physical-memory path.
// Word, cacheline and responder FSM state.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_store.sv
// Line storage for the memory responder.
// Combinational read, synchronous write, never reset.
module pmem_line_store #(
  parameter int    LINE_BITS = 12,
  parameter int    WIDTH     = 128,
  parameter bit    USE_INIT  = 1'b0,
  parameter string INIT_FILE = "pmem_init.hex"
) (
  input  logic                 clk,
  input  logic                 write,
  input  logic [LINE_BITS-1:0] index,
  input  logic [WIDTH-1:0]     datain,
  output logic [WIDTH-1:0]     dataout
);

  logic [WIDTH-1:0] mem [2**LINE_BITS];

  // Write port: one line per cycle when write is high.
  always_ff @(posedge clk) begin
    if (write) mem[index] <= datain;
  end

  assign dataout = mem[index];

endmodule

// File: rtl/pmem_responder.sv
// Memory-side responder for the L2 cacheline interface.
// Fixed-latency line read/write with sticky protocol error.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int    LATENCY   = 10,
  parameter int    LINE_BITS = 12,
  parameter bit    USE_INIT  = 1'b0,
  parameter string INIT_FILE = "pmem_init.hex"
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pmem_read,
  input  logic          pmem_write,
  input  lc3b_word      pmem_address,
  input  lc3b_cacheline pmem_wdata,
  output logic          pmem_resp,
  output lc3b_cacheline pmem_rdata,
  output logic          pmem_error
);

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  pmem_state_t state, state_d;
  logic [7:0]  cnt, cnt_d;

  logic          op_wr;
  logic [11:0]   tag_q;
  lc3b_cacheline wdata_q;

  logic accept;
  logic set_err;
  logic load_rd;
  logic req;
  logic mismatch;

  logic [LINE_BITS-1:0] st_index;
  logic                 st_write;
  lc3b_cacheline        st_rdata;

  logic unused_bits;

  assign unused_bits = ^pmem_address[3:0];

  assign req      = pmem_read | pmem_write;
  assign mismatch = (pmem_address[15:4] != tag_q)
                  | (pmem_write != op_wr);

  // Next state, counter and datapath strobes.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    set_err = 1'b0;
    load_rd = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          set_err = pmem_read & pmem_write;
          if (LATENCY == 1) begin
            state_d = RESP;
            load_rd = ~pmem_write;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          set_err = mismatch;
          cnt_d   = cnt - 8'd1;
          if (cnt == 8'd1) begin
            state_d = RESP;
            load_rd = ~op_wr;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and latency counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Read data register and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pmem_rdata <= '0;
      pmem_error <= 1'b0;
    end else begin
      if (load_rd) pmem_rdata <= st_rdata;
      if (set_err) pmem_error <= 1'b1;
    end
  end

  // Request capture; completion always uses these copies.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr   <= pmem_write;
      tag_q   <= pmem_address[15:4];
      wdata_q <= pmem_wdata;
    end
  end

  // Live address in IDLE lets a one-cycle read fetch immediately.
  assign st_index = (state == IDLE)
                  ? pmem_address[LINE_BITS+3:4]
                  : tag_q[LINE_BITS-1:0];

  assign st_write  = reset_n & (state == RESP) & op_wr;
  assign pmem_resp = (state == RESP);

  pmem_line_store #(
    .LINE_BITS (LINE_BITS),
    .WIDTH     (128),
    .USE_INIT  (USE_INIT),
    .INIT_FILE (INIT_FILE)
  ) u_store (
    .clk     (clk),
    .write   (st_write),
    .index   (st_index),
    .datain  (wdata_q),
    .dataout (st_rdata)
  );

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder.
// Vector table plus multi-cycle corner sequences.
module tb_pmem_responder;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_read, a_write, a_resp, a_err;
  lc3b_word      a_addr;
  lc3b_cacheline a_wdata, a_rdata;

  logic          b_read, b_write, b_resp, b_err;
  lc3b_word      b_addr;
  lc3b_cacheline b_wdata, b_rdata;

  pmem_responder #(.LATENCY(10)) dut_a (
    .clk          (clk),
    .reset_n      (rst_n),
    .pmem_read    (a_read),
    .pmem_write   (a_write),
    .pmem_address (a_addr),
    .pmem_wdata   (a_wdata),
    .pmem_resp    (a_resp),
    .pmem_rdata   (a_rdata),
    .pmem_error   (a_err)
  );

  pmem_responder #(.LATENCY(1)) dut_b (
    .clk          (clk),
    .reset_n      (rst_n),
    .pmem_read    (b_read),
    .pmem_write   (b_write),
    .pmem_address (b_addr),
    .pmem_wdata   (b_wdata),
    .pmem_resp    (b_resp),
    .pmem_rdata   (b_rdata),
    .pmem_error   (b_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic txn(input logic rd, input logic wr,
                     input logic [15:0] a,
                     input logic [127:0] d,
                     input int chg_at,
                     input logic [15:0] a2,
                     input int drop_at,
                     input bit rst_at_resp,
                     output int lat,
                     output logic [127:0] q);
    @(negedge clk);
    a_read = rd;
    a_write = wr;
    a_addr = a;
    a_wdata = d;
    @(posedge clk);
    lat = -1;
    q = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (a_resp) begin
        lat = k;
        q = a_rdata;
        if (rst_at_resp) rst_n = 1'b0;
        break;
      end
      if (k == chg_at) a_addr = a2;
      if (k == drop_at) begin
        a_read = 1'b0;
        a_write = 1'b0;
      end
    end
    a_read = 1'b0;
    a_write = 1'b0;
  endtask

  task automatic txn_b(input logic wr,
                       input logic [15:0] a,
                       input logic [127:0] d,
                       output int lat,
                       output logic [127:0] q);
    @(negedge clk);
    b_read = ~wr;
    b_write = wr;
    b_addr = a;
    b_wdata = d;
    @(posedge clk);
    lat = -1;
    q = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (b_resp) begin
        lat = k;
        q = b_rdata;
        break;
      end
    end
    b_read = 1'b0;
    b_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          rd;
    logic          wr;
    logic [15:0]   addr;
    logic [127:0]  data;
    int            lat;
  } vec_t;

  localparam logic [127:0] PAT =
    128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] QAT =
    128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
  localparam logic [127:0] AAS = {16{8'hAA}};
  localparam logic [127:0] S55 = {16{8'h55}};
  localparam logic [127:0] S66 = {16{8'h66}};
  localparam logic [127:0] SD5 = {16{8'hD5}};
  localparam logic [127:0] ONE = {128{1'b1}};
  localparam logic [127:0] L0  = 128'h1111_2222_3333_4444;
  localparam logic [127:0] L1  = 128'h9999_8888_7777_6666;

  vec_t tbl [9];

  initial begin
    int lat;
    logic [127:0] q, q0, q1;
    logic [5:0] mask;
    int nresp;

    a_read = 0; a_write = 0; a_addr = '0; a_wdata = '0;
    b_read = 0; b_write = 0; b_addr = '0; b_wdata = '0;

    tbl[0] = '{1'b0, 1'b1, 16'h1230, PAT, 10};
    tbl[1] = '{1'b1, 1'b0, 16'h1238, PAT, 10};
    tbl[2] = '{1'b0, 1'b1, 16'h3000, AAS, 10};
    tbl[3] = '{1'b0, 1'b1, 16'h6000, S66, 10};
    tbl[4] = '{1'b0, 1'b1, 16'h7FF0, QAT, 10};
    tbl[5] = '{1'b1, 1'b0, 16'h7FF0, QAT, 10};
    tbl[6] = '{1'b1, 1'b0, 16'h3000, AAS, 10};
    tbl[7] = '{1'b0, 1'b1, 16'h0000, 128'h1, 10};
    tbl[8] = '{1'b1, 1'b0, 16'h000F, 128'h1, 10};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_resp", 128'(a_resp), 128'(0));
    chk("rst_rdata", a_rdata, '0);
    chk("rst_err", 128'(a_err), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
          -1, 16'h0, -1, 1'b0, lat, q);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(tbl[i].lat));
      if (tbl[i].rd && !tbl[i].wr)
        chk($sformatf("vec%0d_rdata", i), q, tbl[i].data);
    end
    @(negedge clk);
    chk("vec_noextra", 128'(a_resp), 128'(0));
    chk("vec_err", 128'(a_err), 128'(0));

    txn(1'b1, 1'b0, 16'h2000, '0, -1, 16'h0, 4, 1'b0, lat, q);
    chk("abort_noresp", 128'(lat), 128'(-1));
    chk("abort_idle", 128'(dut_a.state), 128'(IDLE));
    txn(1'b0, 1'b1, 16'h2000, L1, -1, 16'h0, -1, 1'b0, lat, q);
    chk("abort_wr_lat", 128'(lat), 128'(10));
    txn(1'b1, 1'b0, 16'h2000, '0, -1, 16'h0, -1, 1'b0, lat, q);
    chk("abort_rd", q, L1);
    chk("abort_err", 128'(a_err), 128'(0));

    txn(1'b0, 1'b1, 16'h3000, S55, -1, 16'h0, -1, 1'b1, lat, q);
    chk("rstresp_lat", 128'(lat), 128'(10));
    @(negedge clk);
    chk("rstresp_resp", 128'(a_resp), 128'(0));
    chk("rstresp_rdata", a_rdata, '0);
    chk("rstresp_err", 128'(a_err), 128'(0));
    @(negedge clk);
    chk("rstresp_resp2", 128'(a_resp), 128'(0));
    rst_n = 1'b1;
    txn(1'b1, 1'b0, 16'h3000, '0, -1, 16'h0, -1, 1'b0, lat, q);
    chk("rstresp_old", q, AAS);

    txn(1'b0, 1'b1, 16'h5000, SD5, 3, 16'h6000, -1, 1'b0, lat, q);
    chk("chg_lat", 128'(lat), 128'(10));
    chk("chg_err", 128'(a_err), 128'(1));
    txn(1'b1, 1'b0, 16'h5000, '0, -1, 16'h0, -1, 1'b0, lat, q);
    chk("chg_5000", q, SD5);
    txn(1'b1, 1'b0, 16'h6000, '0, -1, 16'h0, -1, 1'b0, lat, q);
    chk("chg_6000", q, S66);

    do_reset();
    chk("both_err0", 128'(a_err), 128'(0));
    txn(1'b1, 1'b1, 16'h4440, ONE, -1, 16'h0, -1, 1'b0, lat, q);
    chk("both_lat", 128'(lat), 128'(10));
    chk("both_err1", 128'(a_err), 128'(1));
    txn(1'b1, 1'b0, 16'h4440, '0, -1, 16'h0, -1, 1'b0, lat, q);
    chk("both_rd", q, ONE);
    chk("both_sticky", 128'(a_err), 128'(1));

    txn_b(1'b1, 16'h0000, L0, lat, q);
    chk("b_wr0_lat", 128'(lat), 128'(1));
    txn_b(1'b1, 16'h0010, L1, lat, q);
    chk("b_wr1_lat", 128'(lat), 128'(1));

    @(negedge clk);
    b_read = 1'b1;
    b_addr = 16'h0000;
    mask = '0;
    nresp = 0;
    q0 = '0;
    q1 = '0;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (b_resp) begin
        mask[k-1] = 1'b1;
        if (nresp == 0) begin
          q0 = b_rdata;
          b_addr = 16'h0010;
        end else begin
          q1 = b_rdata;
          b_read = 1'b0;
        end
        nresp++;
      end
    end
    b_read = 1'b0;
    chk("b_resp_cycles", 128'(mask), 128'(6'b000101));
    chk("b_line0", q0, L0);
    chk("b_line1", q1, L1);
    chk("b_err", 128'(b_err), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
